mips_mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit for the next-generation datapath; replaces the single-cycle decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback with a Moore FSM.
- Generates the ALU operation code internally from opcode and funct.
- Supports a memory ready handshake and flags illegal opcodes/functs.

---
 rtl/mips_mc_ctrl_pkg.sv | 51 +++++
 rtl/mips_alu_dec.sv | 25 ++
 rtl/mips_mc_ctrl.sv | 158 +++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU operation codes, FSM states and datapath selector values.
package mips_mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: ALU operation code plus a legality flag.
// Unknown functs decode to AND so the ALU sees a harmless operation.
module mips_alu_dec
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_legal
);

  always_comb begin
    alu_op      = ALU_AND;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_NOR:  alu_op = ALU_NOR;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with an optional memory-ready handshake and illegal trap.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W      = 4,
  parameter int USE_MEM_READY = 1,
  parameter int TRAP_ILLEGAL  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                illegal,
  output logic [3:0]          state_o
);

  state_t     state, state_nxt;
  logic       mem_go;
  logic [3:0] dec_op;
  logic       funct_legal;
  logic [3:0] alu_op;

  // Memory states complete on mem_ready, or unconditionally when the
  // handshake is disabled.
  assign mem_go = mem_ready || (USE_MEM_READY == 0);

  mips_alu_dec u_alu_dec (
    .funct      (funct),
    .alu_op     (dec_op),
    .funct_legal(funct_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_go) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_IEXEC;
          default:      state_nxt = (TRAP_ILLEGAL != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_go) state_nxt = S_MEMWB;
      S_MEMWR:  if (mem_go) state_nxt = S_FETCH;
      S_EXEC: begin
        if (funct_legal)            state_nxt = S_RWB;
        else if (TRAP_ILLEGAL != 0) state_nxt = S_HALT;
        else                        state_nxt = S_FETCH;
      end
      S_IEXEC:  state_nxt = S_IWB;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Everything idles to zero (ALU on add) while rst is high, so an aborted
  // instruction cannot leave a strobe asserted for the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_op        = ALU_AND;
    illegal       = 1'b0;
    state_o       = 4'd0;
    if (rst) begin
      alu_op = ALU_ADD;
    end else begin
      state_o = state;
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = mem_go;
          pc_write  = mem_go;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          alu_op    = ALU_ADD;
        end
        S_MEMADR, S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = mem_go;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = dec_op;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
        end
        S_IWB:   reg_write = 1'b1;
        S_HALT:  illegal = 1'b1;
        default: ;
      endcase
    end
    alu_control = ALUCTL_W'(alu_op);
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: two instances (handshake+trap, and neither),
// table-driven instruction sequences, directed corner cases, random model.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] state_o;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         n;
    int         st[6];
  } vec_t;

  localparam logic [5:0] FNS  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  localparam logic [3:0] ALUS [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
  localparam bit USE_MR [2] = '{1'b1, 1'b0};
  localparam bit TRAP   [2] = '{1'b1, 1'b0};

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opc_a = '0, fn_a = '0, opc_b = '0, fn_b = '0;

  logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_ill;
  logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_ill;
  logic [1:0] a_srcb, a_pcsrc, b_srcb, b_pcsrc;
  logic [3:0] a_alu, a_st, b_alu, b_st;
  outs_t oa, ob;

  assign oa = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca,
               a_srcb, a_pcsrc, a_alu, a_ill, a_st};
  assign ob = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca,
               b_srcb, b_pcsrc, b_alu, b_ill, b_st};

  mips_mc_ctrl #(.ALUCTL_W(4), .USE_MEM_READY(1), .TRAP_ILLEGAL(1)) u_a (
    .clk(clk), .rst(rst), .opcode(opc_a), .funct(fn_a), .mem_ready(mem_ready),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .iord(a_iord), .mem_read(a_mrd),
    .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
    .reg_write(a_rw), .alu_src_a(a_srca), .alu_src_b(a_srcb), .pc_src(a_pcsrc),
    .alu_control(a_alu), .illegal(a_ill), .state_o(a_st));

  mips_mc_ctrl #(.ALUCTL_W(4), .USE_MEM_READY(0), .TRAP_ILLEGAL(0)) u_b (
    .clk(clk), .rst(rst), .opcode(opc_b), .funct(fn_b), .mem_ready(mem_ready),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .iord(b_iord), .mem_read(b_mrd),
    .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
    .reg_write(b_rw), .alu_src_a(b_srca), .alu_src_b(b_srcb), .pc_src(b_pcsrc),
    .alu_control(b_alu), .illegal(b_ill), .state_o(b_st));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    for (int i = 0; i < 6; i++) if (fn == FNS[i]) return ALUS[i];
    return 4'b0000;
  endfunction

  function automatic bit fn_legal(input logic [5:0] fn);
    for (int i = 0; i < 6; i++) if (fn == FNS[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic outs_t rst_out();
    outs_t e = '0;
    e.alu_control = 4'b0010;
    return e;
  endfunction

  // Expected outputs of one step, given its state code and memory status.
  function automatic outs_t expect_out(input int ph, input logic [5:0] fn,
                                       input logic mr, input bit use_mr);
    outs_t e = '0;
    logic g = mr || !use_mr;
    e.state_o = 4'(ph);
    case (ph)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
                e.ir_write = g; e.pc_write = g; end
      1:  begin e.alu_src_b = 2'b11; e.alu_control = 4'b0010; end
      2,
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 4'b0010; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      5:  begin e.mem_write = g; e.iord = 1; end
      6:  begin e.alu_src_a = 1; e.alu_control = alu_of(fn); end
      7:  begin e.reg_write = 1; e.reg_dst = 1; end
      8:  begin e.alu_src_a = 1; e.alu_control = 4'b0110; e.pc_write_cond = 1; e.pc_src = 2'b01; end
      9:  begin e.pc_write = 1; e.pc_src = 2'b10; end
      11: e.reg_write = 1;
      15: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_a", oa, rst_out());
      chk("reset_b", ob, rst_out());
    end
  endtask

  task automatic step_check(input string nm, input int sa, input int sb, input logic mr);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = mr;
    #1;
    if (sa >= 0) chk({nm, "_a"}, oa, expect_out(sa, fn_a, mr, 1'b1));
    if (sb >= 0) chk({nm, "_b"}, ob, expect_out(sb, fn_b, mr, 1'b0));
  endtask

  // Random-phase reference model: each instruction becomes a list of steps.
  int prog [2][$];
  int idx [2];
  bit need_new [2];

  task automatic new_instr(input int d);
    int r;
    logic [5:0] op, fn;
    r  = $urandom_range(0, 15);
    fn = FNS[$urandom_range(0, 5)];
    if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
    case (r)
      0, 1, 2, 3, 4: op = 6'b000000;
      5, 6:          op = 6'b100011;
      7, 8:          op = 6'b101011;
      9, 10:         op = 6'b000100;
      11:            op = 6'b000010;
      12, 13:        op = 6'b001000;
      default:       op = 6'($urandom);
    endcase
    if (d == 0) begin opc_a = op; fn_a = fn; end
    else        begin opc_b = op; fn_b = fn; end
    prog[d].delete();
    prog[d].push_back(0);
    prog[d].push_back(1);
    if (op == 6'b100011) begin
      prog[d].push_back(2); prog[d].push_back(3); prog[d].push_back(4);
    end else if (op == 6'b101011) begin
      prog[d].push_back(2); prog[d].push_back(5);
    end else if (op == 6'b000000) begin
      prog[d].push_back(6);
      if (fn_legal(fn)) prog[d].push_back(7);
      else if (TRAP[d]) prog[d].push_back(15);
    end else if (op == 6'b000100) prog[d].push_back(8);
    else if (op == 6'b000010) prog[d].push_back(9);
    else if (op == 6'b001000) begin
      prog[d].push_back(10); prog[d].push_back(11);
    end else if (TRAP[d]) prog[d].push_back(15);
    idx[d] = 0;
    need_new[d] = 1'b0;
  endtask

  task automatic advance(input int d);
    int ph = prog[d][idx[d]];
    if (ph == 15) return;
    if ((ph == 0 || ph == 3 || ph == 5) && USE_MR[d] && !mem_ready) return;
    idx[d]++;
    if (idx[d] >= prog[d].size()) need_new[d] = 1'b1;
  endtask

  vec_t vecs [8];

  initial begin
    int wc, halt_cnt;
    bit do_rst;

    vecs[0] = '{6'b000000, 6'b100111, 4, '{0, 1, 6, 7, 0, 0}};
    vecs[1] = '{6'b000000, 6'b100000, 4, '{0, 1, 6, 7, 0, 0}};
    vecs[2] = '{6'b000000, 6'b101010, 4, '{0, 1, 6, 7, 0, 0}};
    vecs[3] = '{6'b100011, 6'b000000, 5, '{0, 1, 2, 3, 4, 0}};
    vecs[4] = '{6'b101011, 6'b000000, 4, '{0, 1, 2, 5, 0, 0}};
    vecs[5] = '{6'b000100, 6'b000000, 3, '{0, 1, 8, 0, 0, 0}};
    vecs[6] = '{6'b000010, 6'b000000, 3, '{0, 1, 9, 0, 0, 0}};
    vecs[7] = '{6'b001000, 6'b000000, 4, '{0, 1, 10, 11, 0, 0}};

    // Reset, then first fetch; then R-type nor
    do_reset();
    opc_a = 6'b000000; fn_a = 6'b100111;
    step_check("post_rst", 0, 0, 1'b1);
    step_check("nor_dec", 1, -1, 1'b1);
    step_check("nor_exec", 6, -1, 1'b1);
    step_check("nor_rwb", 7, -1, 1'b1);

    // lw with three memory wait cycles in MEMRD
    opc_a = 6'b100011;
    step_check("lw_f", 0, -1, 1'b1);
    step_check("lw_d", 1, -1, 1'b1);
    step_check("lw_ma", 2, -1, 1'b1);
    for (int k = 0; k < 3; k++) step_check($sformatf("lw_wait%0d", k), 3, -1, 1'b0);
    step_check("lw_rd", 3, -1, 1'b1);
    step_check("lw_wb", 4, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      opc_a = vecs[i].op;
      fn_a  = vecs[i].fn;
      for (int k = 0; k < vecs[i].n; k++)
        step_check($sformatf("vec%0d_c%0d", i, k), vecs[i].st[k], -1, 1'b1);
    end

    // sw on the no-handshake instance with mem_ready low; the other stalls in FETCH
    do_reset();
    opc_a = 6'b100011; opc_b = 6'b101011;
    wc = 0;
    for (int k = 0; k < 5; k++) begin
      step_check($sformatf("sw_nr%0d", k), 0, (k == 4) ? 0 : ((k == 3) ? 5 : k), 1'b0);
      wc += int'(b_mwr);
    end
    chk_int("sw_mem_write_cycles", wc, 1);

    // Illegal opcode: trap instance halts, non-trap instance refetches
    do_reset();
    opc_a = 6'b111111; opc_b = 6'b111111;
    for (int k = 0; k < 12; k++)
      step_check($sformatf("ill%0d", k), (k < 2) ? k : 15, k % 2, 1'b1);
    do_reset();
    step_check("ill_cleared", 0, 0, 1'b1);

    // Illegal funct: trap instance halts, the other returns to FETCH from EXEC
    do_reset();
    opc_a = 6'b000000; fn_a = 6'b111111; opc_b = 6'b000000; fn_b = 6'b111111;
    step_check("badfn_f", 0, 0, 1'b1);
    step_check("badfn_d", 1, 1, 1'b1);
    step_check("badfn_x", 6, 6, 1'b1);
    step_check("badfn_h", 15, 0, 1'b1);

    // Random instructions and memory readiness against the step-list model
    do_reset();
    need_new[0] = 1'b1; need_new[1] = 1'b1;
    halt_cnt = 0; do_rst = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (do_rst) begin
        rst = 1'b1;
        #1;
        chk("rand_rst_a", oa, rst_out());
        chk("rand_rst_b", ob, rst_out());
        need_new[0] = 1'b1; need_new[1] = 1'b1;
        do_rst = 1'b0; halt_cnt = 0;
        continue;
      end
      rst = 1'b0;
      for (int d = 0; d < 2; d++) if (need_new[d]) new_instr(d);
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rand_a_c%0d", cyc), oa, expect_out(prog[0][idx[0]], fn_a, mem_ready, 1'b1));
      chk($sformatf("rand_b_c%0d", cyc), ob, expect_out(prog[1][idx[1]], fn_b, mem_ready, 1'b0));
      advance(0);
      advance(1);
      if (!need_new[0] && prog[0][idx[0]] == 15) begin
        halt_cnt++;
        if (halt_cnt >= 3) do_rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench did not complete");
  end

endmodule
